// File: rtl/fpu_pkg.sv
// Shared definitions for the FP add scheduler: float field widths, the
// canonical quiet NaN, field helper constants and the scheduler state enum.
package fpu_pkg;

    localparam int unsigned DATAW = 32;
    localparam int unsigned EXPW  = 8;
    localparam int unsigned MANW  = 23;

    // Canonical qNaN: sign 0, exponent all ones, mantissa MSB only
    localparam logic [DATAW-1:0] QNAN     = 32'h7FC0_0000;
    localparam logic [EXPW-1:0]  EXP_ONES = '1;
    localparam logic [MANW-1:0]  MAN_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/fdecode.sv
// Combinational float field decoder.
// Ports: value (float in); sign_c, nan_c, inf_c, zero_c (class flags).
// Denormals report none of nan/inf/zero.
module fdecode
    import fpu_pkg::*;
(
    input  logic [DATAW-1:0] value,
    output logic             sign_c,
    output logic             nan_c,
    output logic             inf_c,
    output logic             zero_c
);

    logic [EXPW-1:0] exp_f;
    logic [MANW-1:0] man_f;

    assign sign_c = value[DATAW-1];
    assign exp_f  = value[DATAW-2 -: EXPW];
    assign man_f  = value[MANW-1:0];

    assign nan_c  = (exp_f == EXP_ONES) && (man_f != MAN_ZERO);
    assign inf_c  = (exp_f == EXP_ONES) && (man_f == MAN_ZERO);
    assign zero_c = (exp_f == '0)       && (man_f == MAN_ZERO);

endmodule

// File: rtl/fpu_add_sched.sv
// Shares one multi-cycle FP adder core between two requesters.
// Ports: clk/rst (sync, active-high); req0_*/req1_* valid/ready request
// channels with operands a/b; core_start/core_a/core_b launch the core,
// core_done/core_result return its sum; rsp_* is the tagged response
// channel (rsp_id = requester index).
// IEEE special cases are resolved locally; only ordinary operands use the core.
module fpu_add_sched
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [DATAW-1:0] req0_a,
    input  logic [DATAW-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [DATAW-1:0] req1_a,
    input  logic [DATAW-1:0] req1_b,
    output logic             core_start,
    output logic [DATAW-1:0] core_a,
    output logic [DATAW-1:0] core_b,
    input  logic             core_done,
    input  logic [DATAW-1:0] core_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [DATAW-1:0] rsp_result
);

    state_t           state;
    state_t           state_nxt;
    logic             rr;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             sign_a, nan_a, inf_a, zero_a;
    logic             sign_b, nan_b, inf_b, zero_b;
    logic             spec_hit;
    logic [DATAW-1:0] spec_val;

    // Round-robin grant: pointer side wins when both are valid
    assign grant0 = req0_valid & (~rr | ~req1_valid);
    assign grant1 = req1_valid & ( rr | ~req0_valid);

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign core_start = (state == ISSUE);
    assign rsp_valid  = (state == RESP);

    fdecode u_dec_a (
        .value  (core_a),
        .sign_c (sign_a),
        .nan_c  (nan_a),
        .inf_c  (inf_a),
        .zero_c (zero_a)
    );

    fdecode u_dec_b (
        .value  (core_b),
        .sign_c (sign_b),
        .nan_c  (nan_b),
        .inf_c  (inf_b),
        .zero_c (zero_b)
    );

    // Special-case resolution on the latched operands
    always_comb begin
        spec_hit = 1'b1;
        spec_val = QNAN;
        if (nan_a || nan_b) begin
            spec_val = QNAN;
        end else if (inf_a && inf_b) begin
            spec_val = (sign_a != sign_b) ? QNAN : core_a;
        end else if (inf_a) begin
            spec_val = core_a;
        end else if (inf_b) begin
            spec_val = core_b;
        end else if (zero_a && zero_b) begin
            // -0 only when both zeros are negative
            spec_val = {sign_a & sign_b, (DATAW-1)'(0)};
        end else if (zero_a) begin
            spec_val = core_b;
        end else if (zero_b) begin
            spec_val = core_a;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (grant0 || grant1) begin
                    accept    = 1'b1;
                    state_nxt = CLASSIFY;
                end
            end
            CLASSIFY: state_nxt = spec_hit ? RESP : ISSUE;
            ISSUE:    state_nxt = WAIT;
            WAIT:     if (core_done) state_nxt = RESP;
            RESP:     if (rsp_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Operand latch, pointer and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr         <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
        end else begin
            if (accept) begin
                core_a <= grant0 ? req0_a : req1_a;
                core_b <= grant0 ? req0_b : req1_b;
                rsp_id <= grant1;
                rr     <= grant0;
            end
            if ((state == CLASSIFY) && spec_hit) begin
                rsp_result <= spec_val;
            end
            if ((state == WAIT) && core_done) begin
                rsp_result <= core_result;
            end
        end
    end

endmodule

// File: tb/tb_fpu_add_sched.sv
// Directed self-checking bench for fpu_add_sched with a behavioural adder core.
module tb_fpu_add_sched;
    import fpu_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [DATAW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             core_start;
    logic [DATAW-1:0] core_a, core_b;
    logic             core_done = 1'b0;
    logic [DATAW-1:0] core_result = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_id;
    logic [DATAW-1:0] rsp_result;

    int               total = 0;
    int               bad = 0;
    int               core_lat = 2;
    logic [DATAW-1:0] core_val = '0;
    int               start_cnt = 0;

    always #5 clk = ~clk;

    fpu_add_sched dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .core_start  (core_start),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_done   (core_done),
        .core_result (core_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result)
    );

    // Core model: core_done pulses core_lat cycles after the core_start cycle
    always begin
        @(posedge clk);
        #1;
        if (core_start === 1'b1) begin
            start_cnt = start_cnt + 1;
            repeat (core_lat) @(posedge clk);
            #1;
            core_done   = 1'b1;
            core_result = core_val;
            @(posedge clk);
            #1;
            core_done = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (core_start !== 1'b0) begin bad++; $display("FAIL reset_core_start got=%b want=0", core_start); end
        total++; if (core_a !== 32'h0 || core_b !== 32'h0) begin bad++; $display("FAIL reset_core_ab got=%h/%h want=0/0", core_a, core_b); end
        total++; if (rsp_id !== 1'b0 || rsp_result !== 32'h0) begin bad++; $display("FAIL reset_rsp got id=%b res=%h want 0/0", rsp_id, rsp_result); end
        // Probe pointer without accepting: both valid, then withdraw before the edge
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ptr got r0=%b r1=%b want 1/0", req0_ready, req1_ready); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_core_path();
        logic [DATAW-1:0] va [2];
        logic [DATAW-1:0] vb [2];
        logic             vid [2];
        int               s0;
        va[0] = 32'h3F80_0000; vb[0] = 32'h4000_0000; vid[0] = 1'b0;
        va[1] = 32'h0000_0001; vb[1] = 32'h3F80_0000; vid[1] = 1'b1;  // denormal goes to core
        core_lat = 2;
        core_val = 32'h4040_0000;
        for (int i = 0; i < 2; i++) begin
            s0 = start_cnt;
            if (vid[i]) begin req1_valid = 1'b1; req1_a = va[i]; req1_b = vb[i]; end
            else        begin req0_valid = 1'b1; req0_a = va[i]; req0_b = vb[i]; end
            #1;
            total++; if ((vid[i] ? req1_ready : req0_ready) !== 1'b1) begin bad++; $display("FAIL core_ready[%0d] got=0 want=1", i); end
            step();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            #1;
            total++; if (core_start !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL core_classify[%0d] got start=%b rv=%b want 0/0", i, core_start, rsp_valid); end
            step();
            total++; if (core_start !== 1'b1) begin bad++; $display("FAIL core_start[%0d] got=%b want=1", i, core_start); end
            total++; if (core_a !== va[i] || core_b !== vb[i]) begin bad++; $display("FAIL core_ops[%0d] got=%h/%h want=%h/%h", i, core_a, core_b, va[i], vb[i]); end
            step();
            step();
            total++; if (rsp_valid !== 1'b0 || core_a !== va[i]) begin bad++; $display("FAIL core_wait[%0d] got rv=%b a=%h want 0/%h", i, rsp_valid, core_a, va[i]); end
            step();
            total++; if (rsp_valid !== 1'b1 || rsp_id !== vid[i] || rsp_result !== 32'h4040_0000) begin
                bad++; $display("FAIL core_rsp[%0d] got v=%b id=%b res=%h want 1/%b/40400000", i, rsp_valid, rsp_id, rsp_result, vid[i]);
            end
            total++; if (start_cnt !== s0 + 1) begin bad++; $display("FAIL core_start_cnt[%0d] got=%0d want=%0d", i, start_cnt - s0, 1); end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            #1;
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL core_rsp_drop[%0d] got=%b want=0", i, rsp_valid); end
        end
    endtask

    task automatic test_special();
        logic [DATAW-1:0] va [8];
        logic [DATAW-1:0] vb [8];
        logic [DATAW-1:0] ve [8];
        logic             vid [8];
        int               s0;
        va[0] = 32'h7F80_0000; vb[0] = 32'hFF80_0000; ve[0] = 32'h7FC0_0000; vid[0] = 1'b1;
        va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; ve[1] = 32'h8000_0000; vid[1] = 1'b0;
        va[2] = 32'h0000_0000; vb[2] = 32'hC000_0000; ve[2] = 32'hC000_0000; vid[2] = 1'b0;
        va[3] = 32'h7F80_0001; vb[3] = 32'h3F80_0000; ve[3] = 32'h7FC0_0000; vid[3] = 1'b1;
        va[4] = 32'hFF80_0000; vb[4] = 32'h3F80_0000; ve[4] = 32'hFF80_0000; vid[4] = 1'b0;
        va[5] = 32'h7F80_0000; vb[5] = 32'h7F80_0000; ve[5] = 32'h7F80_0000; vid[5] = 1'b1;
        va[6] = 32'h4049_0FDB; vb[6] = 32'h8000_0000; ve[6] = 32'h4049_0FDB; vid[6] = 1'b0;
        va[7] = 32'h8000_0000; vb[7] = 32'h0000_0000; ve[7] = 32'h0000_0000; vid[7] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s0 = start_cnt;
            if (vid[i]) begin req1_valid = 1'b1; req1_a = va[i]; req1_b = vb[i]; end
            else        begin req0_valid = 1'b1; req0_a = va[i]; req0_b = vb[i]; end
            #1;
            total++; if ((vid[i] ? req1_ready : req0_ready) !== 1'b1) begin bad++; $display("FAIL spec_ready[%0d] got=0 want=1", i); end
            step();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            #1;
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL spec_early[%0d] got rv=%b want=0", i, rsp_valid); end
            step();
            total++; if (rsp_valid !== 1'b1 || rsp_id !== vid[i] || rsp_result !== ve[i]) begin
                bad++; $display("FAIL spec_rsp[%0d] got v=%b id=%b res=%h want 1/%b/%h", i, rsp_valid, rsp_id, rsp_result, vid[i], ve[i]);
            end
            total++; if (start_cnt !== s0 || core_start !== 1'b0) begin bad++; $display("FAIL spec_no_core[%0d] got starts=%0d want=0", i, start_cnt - s0); end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int   grants [4];
        int   ngrant = 0;
        int   nresp = 0;
        logic prev_rdy = 1'b0;
        logic cur_rdy;
        rst = 1'b1;
        step();
        rst = 1'b0;
        core_lat = 3;
        core_val = 32'h40E0_0000;
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
        req1_valid = 1'b1; req1_a = 32'h4040_0000; req1_b = 32'h4080_0000;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && nresp < 4; cyc++) begin
            #1;
            total++; if (req0_ready === 1'b1 && req1_ready === 1'b1) begin bad++; $display("FAIL b2b_both_ready cyc=%0d got=11 want at most one", cyc); end
            cur_rdy = req0_ready | req1_ready;
            if (cur_rdy && prev_rdy) begin
                total++; bad++; $display("FAIL b2b_ready_width cyc=%0d got=2 cycles want=1", cyc);
            end
            if (cur_rdy && ngrant < 4) begin
                grants[ngrant] = req1_ready ? 1 : 0;
                ngrant++;
            end
            prev_rdy = cur_rdy;
            if (rsp_valid === 1'b1) begin
                total++; if (rsp_id !== 1'((nresp % 2)) || rsp_result !== 32'h40E0_0000) begin
                    bad++; $display("FAIL b2b_rsp[%0d] got id=%b res=%h want %0d/40e00000", nresp, rsp_id, rsp_result, nresp % 2);
                end
                nresp++;
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        total++; if (nresp != 4 || ngrant != 4) begin bad++; $display("FAIL b2b_count got resp=%0d grants=%0d want 4/4", nresp, ngrant); end
        for (int i = 0; i < ngrant; i++) begin
            total++; if (grants[i] != (i % 2)) begin bad++; $display("FAIL b2b_grant[%0d] got=%0d want=%0d", i, grants[i], i % 2); end
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [DATAW-1:0] held;
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h0000_0000;
        step();
        req0_valid = 1'b0;
        step();
        held = rsp_result;
        total++; if (rsp_valid !== 1'b1 || held !== 32'h3F80_0000) begin bad++; $display("FAIL bp_first got v=%b res=%h want 1/3f800000", rsp_valid, held); end
        req1_valid = 1'b1; req1_a = 32'h0000_0000; req1_b = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h3F80_0000 || rsp_id !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d] got v=%b id=%b res=%h want 1/0/3f800000", i, rsp_valid, rsp_id, rsp_result);
            end
            total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b%b want=00", i, req0_ready, req1_ready); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL bp_hs_ready got=%b want=0", req1_ready); end
        step();
        rsp_ready = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL bp_idle got rv=%b r1=%b want 0/1", rsp_valid, req1_ready); end
        step();
        req1_valid = 1'b0;
        step();
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'h4000_0000) begin
            bad++; $display("FAIL bp_second got v=%b id=%b res=%h want 1/1/40000000", rsp_valid, rsp_id, rsp_result);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        core_lat = 4;
        core_val = 32'h1234_5678;
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
        step();
        req0_valid = 1'b0;
        step();
        total++; if (core_start !== 1'b1) begin bad++; $display("FAIL rw_start got=%b want=1", core_start); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        // Stray core_done arrives during these cycles and must be ignored
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (rsp_valid !== 1'b0 || core_start !== 1'b0) begin bad++; $display("FAIL rw_idle[%0d] got rv=%b cs=%b want 0/0", i, rsp_valid, core_start); end
            step();
        end
        total++; if (core_a !== 32'h0 || rsp_result !== 32'h0) begin bad++; $display("FAIL rw_cleared got a=%h res=%h want 0/0", core_a, rsp_result); end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL rw_ptr got r0=%b r1=%b want 1/0", req0_ready, req1_ready); end
        req1_valid = 1'b0;
        core_lat = 2;
        core_val = 32'h4040_0000;
        step();
        req0_valid = 1'b0;
        step();
        total++; if (core_start !== 1'b1 || core_a !== 32'h3F80_0000) begin bad++; $display("FAIL rw_restart got cs=%b a=%h want 1/3f800000", core_start, core_a); end
        step();
        step();
        step();
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'h4040_0000) begin
            bad++; $display("FAIL rw_rsp got v=%b id=%b res=%h want 1/0/40400000", rsp_valid, rsp_id, rsp_result);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_core_path();
        test_special();
        test_back_to_back();
        test_backpressure();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
